// File: rtl/fpu_sign_seq.sv
// fpu_sign_seq: sign-tracking microsequencer for the FPU.
// Accepts one FP op at a time and steps the sign unit through a per-op
// sequence of sign-function selects. A global stall (fpuhold) freezes it.
// Optional feature macro: FPU_SIGN_SEQ_ABORT_EN adds an abort input that
// cancels the op in flight without a done pulse.
module fpu_sign_seq #(
  parameter int MUL_CYCLES  = 2,
  parameter int DIV_CYCLES  = 28,
  parameter int NORM_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fpuhold,
  input  logic       req_valid,
  input  logic [2:0] req_op,
`ifdef FPU_SIGN_SEQ_ABORT_EN
  input  logic       abort,
`endif
  output logic       req_ready,
  output logic       cyc0_rdy,
  output logic [2:0] asignfunc,
  output logic       busy,
  output logic       done,
  output logic [2:0] done_op
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_LOAD  = 4'd1,
    S_NEGB1 = 4'd2,
    S_NEGB2 = 4'd3,
    S_NEGB3 = 4'd4,
    S_ALIGN = 4'd5,
    S_NORM  = 4'd6,
    S_XOR   = 4'd7,
    S_ITER  = 4'd8,
    S_INV   = 4'd9,
    S_CLR   = 4'd10,
    S_DONE  = 4'd11
  } state_e;

  localparam logic [2:0] OP_FADD = 3'd0;
  localparam logic [2:0] OP_FSUB = 3'd1;
  localparam logic [2:0] OP_FMUL = 3'd2;
  localparam logic [2:0] OP_FDIV = 3'd3;
  localparam logic [2:0] OP_FNEG = 3'd4;
  localparam logic [2:0] OP_FABS = 3'd5;
  localparam logic [2:0] OP_FCMP = 3'd6;
  localparam logic [2:0] OP_FMOV = 3'd7;

  // Counter preloads: the counter holds "remaining cycles minus one".
  localparam logic [4:0] MUL_LOAD  = 5'(MUL_CYCLES - 1);
  localparam logic [4:0] DIV_LOAD  = 5'(DIV_CYCLES - 1);
  localparam logic [4:0] NORM_LOAD = 5'(NORM_CYCLES - 1);

  state_e     state_q, state_d;
  logic [2:0] op_q, op_d;
  logic [4:0] cnt_q, cnt_d;
  logic [2:0] func_q;
  logic       cyc0_q;
  logic       busy_q;
  logic [2:0] done_op_q;
  logic       abort_s;

  // Sign-function select driven while sitting in a given state.
  function automatic logic [2:0] func_of(state_e s);
    case (s)
      S_NEGB1: func_of = 3'd6;
      S_NEGB2: func_of = 3'd1;
      S_NEGB3: func_of = 3'd6;
      S_ALIGN: func_of = 3'd3;
      S_XOR:   func_of = 3'd2;
      S_INV:   func_of = 3'd1;
      S_CLR:   func_of = 3'd5;
      default: func_of = 3'd0;
    endcase
  endfunction

`ifdef FPU_SIGN_SEQ_ABORT_EN
  assign abort_s = abort && !fpuhold && busy_q;
`else
  assign abort_s = 1'b0;
`endif

  // Next-state, opcode and iteration-counter logic.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    if (fpuhold) begin
      state_d = state_q;
    end else if (abort_s) begin
      state_d = S_IDLE;
      cnt_d   = 5'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            op_d    = req_op;
            state_d = S_LOAD;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_LOAD: begin
          case (op_q)
            OP_FADD: state_d = S_ALIGN;
            OP_FSUB: state_d = S_NEGB1;
            OP_FMUL: state_d = S_XOR;
            OP_FDIV: state_d = S_XOR;
            OP_FNEG: state_d = S_INV;
            OP_FABS: state_d = S_CLR;
            OP_FCMP: state_d = S_NEGB1;
            OP_FMOV: state_d = S_DONE;
            default: state_d = S_DONE;
          endcase
        end
        S_NEGB1: state_d = S_NEGB2;
        S_NEGB2: state_d = S_NEGB3;
        S_NEGB3: state_d = S_ALIGN;
        S_ALIGN: begin
          if (op_q == OP_FCMP) begin
            state_d = S_DONE;
          end else begin
            state_d = S_NORM;
            cnt_d   = NORM_LOAD;
          end
        end
        S_XOR: begin
          state_d = S_ITER;
          if (op_q == OP_FMUL) begin
            cnt_d = MUL_LOAD;
          end else begin
            cnt_d = DIV_LOAD;
          end
        end
        S_NORM, S_ITER: begin
          if (cnt_q == 5'd0) begin
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q - 5'd1;
          end
        end
        S_INV:   state_d = S_DONE;
        S_CLR:   state_d = S_DONE;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State registers; decoded outputs are registered from the next state so
  // they stay aligned with state_q and freeze with it under fpuhold.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      op_q      <= 3'd0;
      cnt_q     <= 5'd0;
      func_q    <= 3'd0;
      cyc0_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_op_q <= 3'd0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      func_q    <= func_of(state_d);
      cyc0_q    <= (state_d == S_LOAD);
      busy_q    <= (state_d != S_IDLE);
      done_op_q <= (state_d == S_DONE) ? op_d : 3'd0;
    end
  end

  assign req_ready = (state_q == S_IDLE) && !fpuhold;
  assign done      = (state_q == S_DONE) && !fpuhold && !abort_s;
  assign asignfunc = abort_s ? 3'd0 : func_q;
  assign cyc0_rdy  = abort_s ? 1'b0 : cyc0_q;
  assign busy      = busy_q;
  assign done_op   = done_op_q;

endmodule

// File: tb/tb_fpu_sign_seq.sv
// Directed self-checking bench for fpu_sign_seq with a done scoreboard.
module tb_fpu_sign_seq;

  logic       clk = 1'b0;
  logic       reset, fpuhold, req_valid;
  logic [2:0] req_op;
  logic       abort;
  logic       req_ready, cyc0_rdy, busy, done;
  logic [2:0] asignfunc, done_op;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Sampled outputs (taken at the falling edge before edge number lbl).
  int         lbl;
  logic [2:0] s_func, s_op;
  logic       s_cyc0, s_busy, s_ready, s_done;

  typedef struct {
    logic [2:0] op;
    int         cyc;
  } exp_t;
  exp_t q[$];

  typedef int iq_t[$];

  fpu_sign_seq dut (
    .clk       (clk),
    .reset     (reset),
    .fpuhold   (fpuhold),
    .req_valid (req_valid),
    .req_op    (req_op),
`ifdef FPU_SIGN_SEQ_ABORT_EN
    .abort     (abort),
`endif
    .req_ready (req_ready),
    .cyc0_rdy  (cyc0_rdy),
    .asignfunc (asignfunc),
    .busy      (busy),
    .done      (done),
    .done_op   (done_op)
  );

  always #5 clk = ~clk;

  // Edge counter: edge n is the n-th rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected asignfunc per cycle from LOAD through DONE (default parameters).
  function automatic iq_t seq_of(input logic [2:0] op);
    iq_t s;
    s.push_back(0);
    case (op)
      3'd0: begin s.push_back(3); s.push_back(0); end
      3'd1: begin s.push_back(6); s.push_back(1); s.push_back(6); s.push_back(3); s.push_back(0); end
      3'd2: begin s.push_back(2); repeat (2) s.push_back(0); end
      3'd3: begin s.push_back(2); repeat (28) s.push_back(0); end
      3'd4: s.push_back(1);
      3'd5: s.push_back(5);
      3'd6: begin s.push_back(6); s.push_back(1); s.push_back(6); s.push_back(3); end
      default: ;
    endcase
    s.push_back(0);
    return s;
  endfunction

  // Sample before the next rising edge, score any done pulse, then step.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    lbl     = cyc + 1;
    s_func  = asignfunc;
    s_cyc0  = cyc0_rdy;
    s_busy  = busy;
    s_ready = req_ready;
    s_done  = done;
    s_op    = done_op;
    if (s_done === 1'b1) begin
      check("done_expected", (q.size() != 0), 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        check("done_op", s_op, e.op);
        check("done_cycle", lbl, e.cyc);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input int extra, output int k);
    iq_t s;
    exp_t e;
    s = seq_of(op);
    req_valid = 1'b1;
    req_op    = op;
    tick();
    check("issue_ready", s_ready, 1);
    k = lbl;
    req_valid = 1'b0;
    e.op  = op;
    e.cyc = k + s.size() + extra;
    q.push_back(e);
  endtask

  task automatic follow(input logic [2:0] op);
    iq_t s;
    s = seq_of(op);
    for (int i = 0; i < s.size(); i++) begin
      tick();
      check($sformatf("func_op%0d_c%0d", op, i), s_func, s[i]);
      check($sformatf("cyc0_op%0d_c%0d", op, i), s_cyc0, (i == 0));
      check($sformatf("busy_op%0d_c%0d", op, i), s_busy, 1);
      check($sformatf("done_op%0d_c%0d", op, i), s_done, (i == s.size() - 1));
    end
    tick();
    check("idle_busy", s_busy, 0);
    check("idle_ready", s_ready, 1);
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && q.size() != 0; i++) tick();
    check("wait_done_timeout", q.size(), 0);
  endtask

  initial begin
    int k;
    reset = 1'b1; fpuhold = 1'b0; req_valid = 1'b0; req_op = 3'd0; abort = 1'b0;
    tick();
    tick();
    check("rst_busy", s_busy, 0);
    check("rst_func", s_func, 0);
    check("rst_cyc0", s_cyc0, 0);
    check("rst_done", s_done, 0);
    check("rst_done_op", s_op, 0);
    reset = 1'b0;
    tick();
    check("rst_ready", s_ready, 1);

    // Every opcode with no holds.
    for (int op = 0; op < 8; op++) begin
      issue(3'(op), 0, k);
      follow(3'(op));
    end

    // FDIV with a 3-cycle hold during ITER: done slips by 3 cycles.
    issue(3'd3, 3, k);
    repeat (6) tick();
    fpuhold = 1'b1;
    repeat (3) begin
      tick();
      check("hold_ready", s_ready, 0);
      check("hold_func", s_func, 0);
      check("hold_busy", s_busy, 1);
      check("hold_done", s_done, 0);
    end
    fpuhold = 1'b0;
    wait_done(40);
    repeat (3) tick();

    // Hold across DONE with a pending request held high.
    issue(3'd7, 2, k);
    tick();
    fpuhold = 1'b1; req_valid = 1'b1; req_op = 3'd4;
    repeat (2) begin
      tick();
      check("hdone_done", s_done, 0);
      check("hdone_ready", s_ready, 0);
      check("hdone_busy", s_busy, 1);
    end
    fpuhold = 1'b0;
    tick();
    check("hdone_pulse", s_done, 1);
    check("hdone_ready_in_done", s_ready, 0);
    tick();
    check("hdone_ready_idle", s_ready, 1);
    begin
      exp_t e;
      e.op = 3'd4; e.cyc = lbl + 3;
      q.push_back(e);
    end
    req_valid = 1'b0;
    wait_done(10);
    repeat (2) tick();

    // Reset mid-FMUL while held.
    issue(3'd2, 0, k);
    repeat (2) tick();
    fpuhold = 1'b1; reset = 1'b1;
    tick();
    reset = 1'b0;
    q.delete();
    tick();
    check("rsth_busy", s_busy, 0);
    check("rsth_func", s_func, 0);
    check("rsth_ready", s_ready, 0);
    check("rsth_done", s_done, 0);
    check("rsth_cyc0", s_cyc0, 0);
    fpuhold = 1'b0;
    tick();
    check("rsth_ready_rel", s_ready, 1);
    check("rsth_busy_rel", s_busy, 0);
    repeat (6) tick();

`ifdef FPU_SIGN_SEQ_ABORT_EN
    // Abort during FDIV ITER, then a clean FNEG.
    issue(3'd3, 0, k);
    repeat (5) tick();
    abort = 1'b1;
    tick();
    check("abort_func", s_func, 0);
    check("abort_cyc0", s_cyc0, 0);
    check("abort_done", s_done, 0);
    abort = 1'b0;
    q.delete();
    tick();
    check("abort_busy", s_busy, 0);
    check("abort_ready", s_ready, 1);
    issue(3'd4, 0, k);
    follow(3'd4);
`endif

    check("scoreboard_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
